mem_ctrl: RTL

Single-port memory controller and arbiter between the IF stage (instruction fetch) and the MEM stage (load/store), which share one byte-wide synchronous RAM. It serialises 1/2/4-byte accesses into byte cycles and assembles or splits words little-endian. It raises per-stage stall requests toward the pipeline stall controller, which drives the stall bus sampled by if_id/ex_mem/mem_wb. Load/store has priority over fetch, because the MEM-stage instruction is older.

---
 rtl/mem_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial arbiter/controller sharing one byte RAM between fetch and load/store
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wr,
    input  logic [7:0]  ram_rdata,
    output logic        stall_req_if,
    output logic        stall_req_mem
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      state, state_nx;
    logic [2:0]  cnt, n, nxt, cap, n_ls;
    logic [31:0] base, wdata, asm_q, asm_nx;
    logic        own_ls;
    assign stall_req_if  = if_req & ~if_done;
    assign stall_req_mem = ls_req & ~ls_done;
    assign nxt    = cnt + 3'd1;
    assign cap    = cnt - 3'd1;
    assign n_ls   = ls_size == 2'd0 ? 3'd1 : ls_size == 2'd1 ? 3'd2 : 3'd4;
    assign asm_nx = asm_q | ({24'b0, ram_rdata} << {cap, 3'b000});
    // state register; rdy low freezes the sequence
    always_ff @(posedge clk)
        state <= rst ? IDLE : rdy ? state_nx : state;
    // next state: LS wins over IF; reads end one edge after the last byte capture
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ls_req ? (ls_we ? WRITE : READ) : if_req ? READ : IDLE;
            READ:    state_nx = cnt == n ? DONE : READ;
            WRITE:   state_nx = nxt == n ? DONE : WRITE;
            default: state_nx = IDLE;
        endcase
    end
    // datapath: address/byte sequencing, word assembly and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            n         <= '0;
            base      <= '0;
            wdata     <= '0;
            asm_q     <= '0;
            own_ls    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wr    <= 1'b0;
            if_data   <= '0;
            ls_rdata  <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: if (ls_req | if_req) begin
                    cnt       <= '0;
                    n         <= ls_req ? n_ls : 3'd4;
                    base      <= ls_req ? ls_addr : if_addr;
                    own_ls    <= ls_req;
                    wdata     <= ls_wdata;
                    asm_q     <= '0;
                    ram_addr  <= ls_req ? ls_addr : if_addr;
                    ram_wdata <= ls_wdata[7:0];
                    ram_wr    <= ls_req & ls_we;
                end
                READ: begin
                    cnt <= nxt;
                    if (nxt < n) ram_addr <= base + {29'b0, nxt};
                    if (cnt != 3'd0) asm_q <= asm_nx;
                    if (cnt == n) begin
                        if (own_ls) begin
                            ls_rdata <= asm_nx;
                            ls_done  <= 1'b1;
                        end else begin
                            if_data <= asm_nx;
                            if_done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    cnt <= nxt;
                    if (nxt < n) begin
                        ram_addr  <= base + {29'b0, nxt};
                        ram_wdata <= wdata[{nxt[1:0], 3'b000} +: 8];
                    end else begin
                        ram_wr  <= 1'b0;
                        ls_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
